bin_to_bcd_scan: RTL



---
 rtl/bin_to_bcd_scan.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_scan.sv
// 14-bit binary to 4-digit BCD converter (sequential double-dabble) with a
// latched display register and a time-multiplexed, active-low digit scanner.
module bin_to_bcd_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BIN_W       = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [15:0]      value_bcd,
    output logic [3:0]       bcd,
    output logic [3:0]       an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BIN_W-1:0] BIN_LIMIT = BIN_W'(9999);
    localparam logic [3:0]       LAST_ITER = 4'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] opnd_q, opnd_d;
    logic [15:0]      acc_q, acc_d;
    logic [3:0]       iter_q, iter_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      value_q, value_d;

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       bcd_q, bcd_d;

    logic [15:0]      acc_adj;
    logic [3:0]       lz_blank;

    // Per-nibble add-3 correction; nibbles never carry into each other.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_add3
            assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                                        (acc_q[4*gi +: 4] + 4'd3) :
                                        acc_q[4*gi +: 4];
        end
    endgenerate

    // A digit is blank when it and every higher digit are zero; units always shows.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lz
            if (gi == 0) begin : g_units
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = blank_lz && (value_q[15:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        value_d    = value_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d     = (bin_in > BIN_LIMIT) ? BIN_LIMIT : bin_in;
                    ovf_pend_d = (bin_in > BIN_LIMIT);
                    acc_d      = 16'h0000;
                    iter_d     = 4'd0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                acc_d  = {acc_adj[14:0], opnd_q[BIN_W-1]};
                opnd_d = {opnd_q[BIN_W-2:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                value_d = acc_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // The scanner recomputes an/bcd only on a slot advance, so a mid-slot
    // value update waits for the next slot.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        dig_d      = dig_q;
        an_d       = an_q;
        bcd_d      = bcd_q;
        if (scan_cnt_q == CNT_MAX) begin
            scan_cnt_d = '0;
            dig_d      = dig_q + 2'd1;
            if (lz_blank[dig_d]) begin
                an_d  = 4'b1111;
                bcd_d = 4'h0;
            end else begin
                an_d  = ~(4'b0001 << dig_d);
                bcd_d = value_q[{dig_d, 2'b00} +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opnd_q     <= '0;
            acc_q      <= 16'h0000;
            iter_q     <= 4'd0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            value_q    <= 16'h0000;
            scan_cnt_q <= '0;
            dig_q      <= 2'd0;
            an_q       <= 4'b1110;
            bcd_q      <= 4'h0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            value_q    <= value_d;
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            an_q       <= an_d;
            bcd_q      <= bcd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign value_bcd = value_q;
    assign bcd       = bcd_q;
    assign an        = an_q;

endmodule
